vliw_fetch_unit: RTL and testbench
==================================

// Module: vliw_fetch_unit
// PURPOSE
//  Parametrised VLIW instruction fetch stage; successor to the fixed 2-slot IF stage.
//  Fetches SLOTS x SLOT_W bundles from instruction memory over a valid/ready request
//  and in-order response interface. Buffers bundles in an FQ_DEPTH fetch queue that feeds ID.
//  Applies exception/branch/jump redirects with queue flush and in-flight response drop.
// PARAMETERS
//  ADDR_W     32  PC / memory address width
//  SLOTS      2   instruction slots per bundle (>=1)
//  SLOT_W     16  bits per slot; multiple of 8
//  FQ_DEPTH   4   fetch-queue entries (power of 2, >=2); also the max in-flight requests
//  RESET_PC   0   PC loaded on reset
//  EXC_VECTOR 'h8 PC loaded on exception
// PORTS
//  clk            in   1              clock, rising edge
//  reset          in   1              synchronous, active-high
//  pc_stall       in   1              1 = hold PC, issue no new requests (hazard stall)
//  exc_valid      in   1              exception redirect to EXC_VECTOR
//  br_taken       in   1              resolved taken branch (isBranch & flag)
//  br_target      in   ADDR_W         branch target
//  jmp_valid      in   1              jump redirect
//  jmp_target     in   ADDR_W         jump target
//  imem_req_valid out  1              fetch request valid
//  imem_req_ready in   1              memory accepts request
//  imem_req_addr  out  ADDR_W         bundle address
//  imem_rsp_valid in   1              response valid; responses in request order, 1 per req
//  imem_rsp_data  in   SLOTS*SLOT_W   bundle; slot 0 in LSBs
//  bundle_valid   out  1              head-of-queue bundle valid to ID
//  bundle_data    out  SLOTS*SLOT_W   bundle to ID
//  bundle_pc      out  ADDR_W         PC of bundle_data
//  dec_ready      in   1              ID consumes bundle this cycle
// BEHAVIOUR
//  - BB = SLOTS*SLOT_W/8. PC arithmetic is mod 2^ADDR_W, so the PC wraps silently.
//  - Reset:
//    - fetch_pc = rsp_pc = RESET_PC; queue empty; inflight = drop_cnt = 0.
//    - imem_req_valid = 0 and bundle_valid = 0 during the reset cycle.
//    - Reset mid-operation abandons everything. Responses arriving after reset still
//      count; the environment must drain memory before reset is released.
//  - redirect = exc_valid | br_taken | jmp_valid.
//    - Priority: exc > branch > jump. tgt = EXC_VECTOR / br_target / jmp_target.
//  - Issue: imem_req_valid = !reset & !pc_stall & !redirect & (occ + inflight < FQ_DEPTH).
//    - imem_req_addr = fetch_pc.
//    - Handshake (valid & ready): fetch_pc += BB; inflight++.
//    - Address is held stable while valid & !ready. Valid may drop only on redirect/stall.
//  - Response (imem_rsp_valid): inflight--.
//    - If drop_cnt > 0 (or redirect this cycle): discard the response; drop_cnt--.
//    - Else: push {data, rsp_pc}; rsp_pc += BB.
//    - The credit rule guarantees a free entry; push and pop in the same cycle at full is legal.
//  - Output: bundle_valid = occ != 0 & !redirect; data/pc from head.
//    - Pop on bundle_valid & dec_ready. Zero added latency: a push is visible the next cycle.
//  - Redirect cycle (registered effect next cycle):
//    - Queue flushed; fetch_pc = rsp_pc = tgt.
//    - drop_cnt = inflight + issued_this_cycle(0) - rsp_valid_this_cycle.
//    - First new request is issued the cycle after.
//  - pc_stall: PC frozen, no issue; responses still accepted, queue still drains.
//    - Redirect overrides stall.
//  - Latency: redirect at cycle t -> req at tgt at t+1; bundle at t+1+mem_lat+1.
// TESTING
//  1. Reset, ready=1, 1-cycle mem, dec_ready=1 -> addrs 0,4,8..; bundles pc 0,4,8 back-to-back.
//  2. dec_ready=0 -> 4 bundles queued, then imem_req_valid=0. Release -> pc 0..12 in order, none lost.
//  3. br_taken, br_target=0x40, 2 in flight -> both responses dropped; next bundle_pc = 0x40.
//  4. exc_valid + br_taken + jmp_valid same cycle -> next req addr = EXC_VECTOR (0x8).
//  5. pc_stall 3 cycles, ready=1 -> no new reqs; queue drains; resume at held PC.
//  6. SLOTS=4, SLOT_W=32, start pc 0xFFFFFFF0 -> addrs F0, 00, 10; wraps; 128-bit bundles intact.

Source files
------------

// File: rtl/vliw_fetch_unit_if.sv
// Instruction-memory fetch bus: valid/ready request channel plus in-order,
// one-per-request response channel.
//   imem_req_valid  master->slave  request valid
//   imem_req_ready  slave->master  request accepted
//   imem_req_addr   master->slave  bundle address
//   imem_rsp_valid  slave->master  response valid (request order)
//   imem_rsp_data   slave->master  bundle data, slot 0 in LSBs
interface vliw_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/vliw_fetch_unit.sv
// VLIW instruction fetch stage. Issues bundle fetches to instruction memory,
// buffers responses in a FQ_DEPTH-entry fetch queue feeding decode, and
// applies exception/branch/jump redirects (queue flush + in-flight drop).
// Ports:
//   clk, reset         clock / synchronous active-high reset
//   pc_stall           hold PC, issue nothing
//   exc_valid          redirect to EXC_VECTOR (highest priority)
//   br_taken/br_target taken-branch redirect
//   jmp_valid/jmp_target jump redirect (lowest priority)
//   imem               fetch bus (master side)
//   bundle_valid/bundle_data/bundle_pc  head-of-queue bundle to decode
//   dec_ready          decode consumes the head bundle
module vliw_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       SLOTS      = 2,
  parameter int unsigned       SLOT_W     = 16,
  parameter int unsigned       FQ_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pc_stall,
  input  logic                      exc_valid,
  input  logic                      br_taken,
  input  logic [ADDR_W-1:0]         br_target,
  input  logic                      jmp_valid,
  input  logic [ADDR_W-1:0]         jmp_target,
  vliw_fetch_unit_if.master         imem,
  output logic                      bundle_valid,
  output logic [SLOTS*SLOT_W-1:0]   bundle_data,
  output logic [ADDR_W-1:0]         bundle_pc,
  input  logic                      dec_ready
);
  localparam int unsigned       DATA_W = SLOTS * SLOT_W;
  localparam int unsigned       PTR_W  = $clog2(FQ_DEPTH);
  localparam int unsigned       CNT_W  = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BB_INC = ADDR_W'(DATA_W / 8);

  logic [ADDR_W-1:0] fetchPc, rspPc, redirTgt;
  logic [CNT_W-1:0]  occ, inflight, dropCnt;
  logic [CNT_W:0]    credits;
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [DATA_W-1:0] fqData [FQ_DEPTH];
  logic [ADDR_W-1:0] fqPc   [FQ_DEPTH];
  logic              redirect, reqFire, push, pop;

  always_comb begin
    redirect = exc_valid | br_taken | jmp_valid;
    if (exc_valid)     redirTgt = EXC_VECTOR;
    else if (br_taken) redirTgt = br_target;
    else               redirTgt = jmp_target;

    // Queued plus in-flight bundles never exceed the queue size, so every
    // response is guaranteed a free entry.
    credits = {1'b0, occ} + {1'b0, inflight};
    imem.imem_req_valid = !reset && !pc_stall && !redirect &&
                          (credits < (CNT_W+1)'(FQ_DEPTH));
    imem.imem_req_addr  = fetchPc;
    reqFire = imem.imem_req_valid & imem.imem_req_ready;

    // Responses belonging to the pre-redirect stream are discarded.
    push = imem.imem_rsp_valid & !redirect & (dropCnt == '0);

    bundle_valid = !reset && (occ != '0) && !redirect;
    bundle_data  = fqData[rdPtr];
    bundle_pc    = fqPc[rdPtr];
    pop          = bundle_valid & dec_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc  <= RESET_PC;
      rspPc    <= RESET_PC;
      occ      <= '0;
      inflight <= '0;
      dropCnt  <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
    end else if (redirect) begin
      fetchPc  <= redirTgt;
      rspPc    <= redirTgt;
      occ      <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      // Nothing issues on a redirect cycle; everything still outstanding
      // after this cycle's response (if any) must be dropped.
      inflight <= inflight - CNT_W'(imem.imem_rsp_valid);
      dropCnt  <= inflight - CNT_W'(imem.imem_rsp_valid);
    end else begin
      if (reqFire) fetchPc <= fetchPc + BB_INC;
      inflight <= inflight + CNT_W'(reqFire) - CNT_W'(imem.imem_rsp_valid);
      if (imem.imem_rsp_valid && dropCnt != '0) dropCnt <= dropCnt - CNT_W'(1);
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
        rspPc <= rspPc + BB_INC;
      end
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fqData[wrPtr] <= imem.imem_rsp_data;
      fqPc[wrPtr]   <= rspPc;
    end
  end
endmodule

// File: tb/tb_vliw_fetch_unit.sv
module tb_vliw_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance (2 x 16-bit slots, 4-byte bundles)
  logic        rst0, stall, exc, br, jmp, decRdy;
  logic [31:0] brT, jmpT;
  logic        bv0;
  logic [31:0] bd0, bpc0;
  vliw_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) if0 ();

  vliw_fetch_unit dut0 (
    .clk(clk), .reset(rst0), .pc_stall(stall), .exc_valid(exc),
    .br_taken(br), .br_target(brT), .jmp_valid(jmp), .jmp_target(jmpT),
    .imem(if0), .bundle_valid(bv0), .bundle_data(bd0), .bundle_pc(bpc0),
    .dec_ready(decRdy)
  );

  // Wide instance (4 x 32-bit slots) starting near the top of the address space
  logic         rst1, dec1;
  logic         bv1;
  logic [127:0] bd1;
  logic [31:0]  bpc1;
  vliw_fetch_unit_if #(.ADDR_W(32), .DATA_W(128)) if1 ();

  vliw_fetch_unit #(.SLOTS(4), .SLOT_W(32), .RESET_PC(32'hFFFF_FFF0)) dut1 (
    .clk(clk), .reset(rst1), .pc_stall(1'b0), .exc_valid(1'b0),
    .br_taken(1'b0), .br_target(32'h0), .jmp_valid(1'b0), .jmp_target(32'h0),
    .imem(if1), .bundle_valid(bv1), .bundle_data(bd1), .bundle_pc(bpc1),
    .dec_ready(dec1)
  );

  int unsigned nChecks = 0, nErr = 0, cyc = 0;
  int unsigned fixLat = 0, maxLat = 0;
  bit          rndRdy = 0, rndDec = 0;

  // Reference model: outstanding requests (oldest first) and queued bundles.
  typedef struct { logic [31:0] addr; int unsigned due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  req_t        inflQ[$];
  ent_t        fq[$];
  logic [31:0] fetchPc;

  function automatic logic [31:0] h(input logic [31:0] a);
    logic [31:0] p;
    p = a * 32'h9E37_79B1;
    return p ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [127:0] h128(input logic [31:0] a);
    return {h(a + 32'd12), h(a + 32'd8), h(a + 32'd4), h(a)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of dut0: drive at negedge, check, advance the model, wait.
  task automatic cycle();
    logic        expRv, expBv, redir, fire, pop;
    logic [31:0] tgt;
    req_t        r;
    if (rndRdy) if0.imem_req_ready = ($urandom_range(0, 1) == 1);
    if (rndDec) decRdy = ($urandom_range(0, 3) != 0);
    if0.imem_rsp_valid = 1'b0;
    if0.imem_rsp_data  = '0;
    if (!rst0 && inflQ.size() != 0 && inflQ[0].due <= cyc) begin
      if0.imem_rsp_valid = 1'b1;
      if0.imem_rsp_data  = h(inflQ[0].addr);
    end
    #1;
    redir = exc | br | jmp;
    tgt   = exc ? 32'h8 : (br ? brT : jmpT);
    expRv = !rst0 && !stall && !redir && (fq.size() + inflQ.size() < 4);
    expBv = !rst0 && fq.size() != 0 && !redir;
    chk("req_valid", if0.imem_req_valid, expRv);
    if (expRv) chk("req_addr", if0.imem_req_addr, fetchPc);
    chk("bundle_valid", bv0, expBv);
    if (expBv) begin
      chk("bundle_pc", bpc0, fq[0].pc);
      chk("bundle_data", bd0, fq[0].data);
    end
    fire = expRv && if0.imem_req_ready;
    pop  = expBv && decRdy;
    if (rst0) begin
      fq.delete();
      inflQ.delete();
      fetchPc = 32'h0;
    end else begin
      if (pop) void'(fq.pop_front());
      if (if0.imem_rsp_valid) begin
        r = inflQ.pop_front();
        if (!r.stale && !redir) fq.push_back('{r.addr, h(r.addr)});
      end
      if (redir) begin
        fq.delete();
        foreach (inflQ[i]) inflQ[i].stale = 1'b1;
        fetchPc = tgt;
      end else if (fire) begin
        inflQ.push_back('{fetchPc, cyc + 1 + fixLat + $urandom_range(0, maxLat), 1'b0});
        fetchPc = fetchPc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] expAddr, expPc, pendAddr;
    bit          pend;
    rst0 = 1; stall = 0; exc = 0; br = 0; jmp = 0; decRdy = 1;
    brT = '0; jmpT = '0;
    if0.imem_req_ready = 1; if0.imem_rsp_valid = 0; if0.imem_rsp_data = '0;
    rst1 = 1; dec1 = 1;
    if1.imem_req_ready = 1; if1.imem_rsp_valid = 0; if1.imem_rsp_data = '0;
    fetchPc = '0;
    @(negedge clk);

    // Reset, then streaming with a 1-cycle memory
    repeat (2) cycle();
    rst0 = 0;
    repeat (8) cycle();

    // Decode back-pressure fills the queue and stops issue; release drains in order
    decRdy = 0;
    repeat (8) cycle();
    decRdy = 1;
    repeat (6) cycle();

    // Taken branch with several responses outstanding
    fixLat = 2;
    repeat (5) cycle();
    br = 1; brT = 32'h40;
    cycle();
    br = 0; fixLat = 0;
    for (int i = 0; i < 12 && fq.size() == 0; i++) cycle();
    #1;
    chk("br_first_valid", bv0, 1'b1);
    chk("br_first_pc", bpc0, 32'h40);
    repeat (6) cycle();

    // Simultaneous redirects: exception wins
    exc = 1; br = 1; jmp = 1; brT = 32'h100; jmpT = 32'h200;
    cycle();
    exc = 0; br = 0; jmp = 0;
    #1;
    chk("prio_req_valid", if0.imem_req_valid, 1'b1);
    chk("prio_req_addr", if0.imem_req_addr, 32'h8);
    repeat (6) cycle();

    // Stall for three cycles, then resume at the held PC
    stall = 1;
    repeat (3) cycle();
    stall = 0;
    repeat (6) cycle();

    // Randomised traffic
    rndRdy = 1; rndDec = 1; maxLat = 3;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 9) == 0);
      exc   = ($urandom_range(0, 59) == 0);
      br    = ($urandom_range(0, 29) == 0);
      jmp   = ($urandom_range(0, 29) == 0);
      brT   = $urandom & 32'hFFFF_FFFC;
      jmpT  = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    stall = 0; exc = 0; br = 0; jmp = 0;
    rndRdy = 0; rndDec = 0; maxLat = 0;
    if0.imem_req_ready = 1; decRdy = 1;
    repeat (20) cycle();

    // Wide bundles with PC wrap-around
    #1;
    chk("w_reset_req_valid", if1.imem_req_valid, 1'b0);
    chk("w_reset_bundle_valid", bv1, 1'b0);
    @(posedge clk); @(negedge clk);
    rst1 = 0;
    expAddr = 32'hFFFF_FFF0; expPc = 32'hFFFF_FFF0;
    pend = 0; pendAddr = '0;
    for (int i = 0; i < 6; i++) begin
      if1.imem_rsp_valid = pend;
      if1.imem_rsp_data  = h128(pendAddr);
      #1;
      chk("w_req_valid", if1.imem_req_valid, 1'b1);
      chk("w_req_addr", if1.imem_req_addr, expAddr);
      chk("w_bundle_valid", bv1, i >= 2);
      if (i >= 2) begin
        chk("w_bundle_pc", bpc1, expPc);
        chk("w_bundle_data", bd1, h128(expPc));
        expPc = expPc + 32'd16;
      end
      pend = 1; pendAddr = expAddr;
      expAddr = expAddr + 32'd16;
      @(posedge clk); @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end
endmodule
